// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction fetch path.
package cpu_pkg;

    // Default width of an i_mem byte address and of every PC.
    localparam int I_ADDR_W = 16;

    // Thumb NOP encoding.
    localparam logic [15:0] THUMB_NOP = 16'hBF00;

    // Fetch FSM: the high byte is read first, then the low byte.
    typedef enum logic {
        FETCH_HI = 1'b0,
        FETCH_LO = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO that holds fetched halfwords together with their PC.
module if_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Storage, pointers and occupancy; flush empties the FIFO and wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: reads two bytes per Thumb halfword from i_mem
// (high byte at the even address), queues {instr, pc} and hands them to decode.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = I_ADDR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int FIFO_W = 16 + ADDR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              lo_pend_q, lo_pend_d;
    logic [7:0]        hi_q, hi_d;

    logic              push;
    logic              pop;
    logic [FIFO_W-1:0] head_data;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              slot_free;

    // A hi read reserves a FIFO slot for the halfword it starts, counting the
    // lo byte still returning and any entry leaving this cycle.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, lo_pend_q} - {{CNT_W{1'b0}}, pop};
    assign slot_free = occupancy < (CNT_W + 1)'(DEPTH);

    // State register: fetch FSM plus the fetch PC and byte-assembly registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH_HI;
            fpc_q     <= RESET_PC;
            lo_pend_q <= 1'b0;
            hi_q      <= '0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            lo_pend_q <= lo_pend_d;
            hi_q      <= hi_d;
        end
    end

    // Next-state logic; a redirect overrides everything and restarts at an even PC.
    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        lo_pend_d = lo_pend_q;
        hi_d      = hi_q;
        unique case (state_q)
            FETCH_HI: begin
                lo_pend_d = 1'b0;
                if (slot_free) begin
                    state_d = FETCH_LO;
                end
            end
            FETCH_LO: begin
                hi_d      = mem_rdata;
                fpc_d     = fpc_q + ADDR_W'(2);
                lo_pend_d = 1'b1;
                state_d   = FETCH_HI;
            end
        endcase
        if (redirect_valid) begin
            state_d   = FETCH_HI;
            fpc_d     = redirect_pc & ~ADDR_W'(1);
            lo_pend_d = 1'b0;
        end
    end

    // Output logic: memory strobe/address, FIFO push/pop and the decode handshake.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        if (rst && !redirect_valid) begin
            if (state_q == FETCH_LO) begin
                mem_rd_en = 1'b1;
                mem_addr  = fpc_q + ADDR_W'(1);
            end else begin
                mem_rd_en = slot_free;
                mem_addr  = fpc_q;
            end
        end else if (rst) begin
            mem_addr = (state_q == FETCH_LO) ? fpc_q + ADDR_W'(1) : fpc_q;
        end
        push      = (state_q == FETCH_HI) && lo_pend_q && !redirect_valid;
        out_valid = rst && !redirect_valid && (fifo_count != '0);
        pop       = out_valid && out_ready;
        out_instr = head_data[FIFO_W-1:ADDR_W];
        out_pc    = head_data[ADDR_W-1:0];
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(FIFO_W)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (rst),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_data_i({hi_q, mem_rdata, fpc_q - ADDR_W'(2)}),
        .pop_i      (pop),
        .head_data_o(head_data),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for the instruction fetch unit: a per-cycle vector table
// for the main flows plus hand-written wrap-around and async-reset sequences.
module tb_if_fetch_unit;
    import cpu_pkg::*;

    typedef struct {
        logic        doReset;
        logic        ready;
        logic        redir;
        logic [15:0] redirPc;
        logic        expRdEn;
        logic [15:0] expAddr;
        logic        expValid;
        logic [15:0] expInstr;
        logic [15:0] expPc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        memRdEnA, memRdEnB;
    logic [15:0] memAddrA, memAddrB;
    logic [7:0]  memRdataA = '0, memRdataB = '0;
    logic        outValidA, outValidB;
    logic        outReadyA = 1'b0;
    logic        outReadyB = 1'b1;
    logic [15:0] outInstrA, outInstrB;
    logic [15:0] outPcA, outPcB;
    logic        redirValid = 1'b0;
    logic [15:0] redirPc = '0;

    logic [7:0]  memA [0:65535];
    logic [7:0]  memB [0:65535];

    int checks = 0;
    int passes = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    // Byte memories answer one cycle after the strobe.
    always @(posedge clk) begin
        if (memRdEnA) memRdataA <= memA[memAddrA];
        if (memRdEnB) memRdataB <= memB[memAddrB];
    end

    if_fetch_unit #(.ADDR_W(16), .DEPTH(2), .RESET_PC(16'h0000)) dutA (
        .clk(clk), .rst(rst),
        .mem_rd_en(memRdEnA), .mem_addr(memAddrA), .mem_rdata(memRdataA),
        .out_valid(outValidA), .out_ready(outReadyA),
        .out_instr(outInstrA), .out_pc(outPcA),
        .redirect_valid(redirValid), .redirect_pc(redirPc)
    );

    if_fetch_unit #(.ADDR_W(16), .DEPTH(2), .RESET_PC(16'hFFFE)) dutB (
        .clk(clk), .rst(rst),
        .mem_rd_en(memRdEnB), .mem_addr(memAddrB), .mem_rdata(memRdataB),
        .out_valid(outValidB), .out_ready(outReadyB),
        .out_instr(outInstrB), .out_pc(outPcB),
        .redirect_valid(1'b0), .redirect_pc(16'h0000)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic doReset, input logic ready, input logic redir,
                                input logic [15:0] rpc, input logic rdEn, input logic [15:0] addr,
                                input logic valid, input logic [15:0] instr, input logic [15:0] pc);
        vec_t v;
        v.doReset = doReset; v.ready = ready; v.redir = redir; v.redirPc = rpc;
        v.expRdEn = rdEn; v.expAddr = addr; v.expValid = valid;
        v.expInstr = instr; v.expPc = pc;
        return v;
    endfunction

    // Holds reset for two cycles, checks reset outputs, releases at a falling edge.
    task automatic doReset();
        outReadyA  = 1'b0;
        redirValid = 1'b0;
        rst = 1'b0;
        #2;
        check("reset rd_en", {15'b0, memRdEnA}, 16'h0);
        check("reset addr", memAddrA, 16'h0);
        check("reset valid", {15'b0, outValidA}, 16'h0);
        check("reset instr", outInstrA, 16'h0);
        check("reset pc", outPcA, 16'h0);
        check("reset addrB", memAddrB, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        outReadyA  = v.ready;
        redirValid = v.redir;
        redirPc    = v.redirPc;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        check($sformatf("row%0d rd_en", idx), {15'b0, memRdEnA}, {15'b0, v.expRdEn});
        if (v.expRdEn) check($sformatf("row%0d addr", idx), memAddrA, v.expAddr);
        check($sformatf("row%0d valid", idx), {15'b0, outValidA}, {15'b0, v.expValid});
        if (v.expValid) begin
            check($sformatf("row%0d instr", idx), outInstrA, v.expInstr);
            check($sformatf("row%0d pc", idx), outPcA, v.expPc);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            memA[i] = 8'h00;
            memB[i] = 8'h00;
        end
        memA[0] = 8'hBF; memA[1] = 8'h00; memA[2] = 8'h20; memA[3] = 8'h3C;
        memA[4] = 8'h11; memA[5] = 8'h22; memA[6] = 8'h33; memA[7] = 8'h44;
        memA[16'h12] = 8'h48; memA[16'h13] = 8'h7A;
        memB[16'hFFFE] = 8'hBF; memB[16'hFFFF] = 8'h00;
        memB[0] = 8'h20; memB[1] = 8'h05;

        // Streaming with decode always ready: one halfword every two cycles.
        vecs.push_back(mk(1,1,0,0, 1,16'h0, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h1, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h2, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h3, 1,THUMB_NOP,16'h0));
        vecs.push_back(mk(0,1,0,0, 1,16'h4, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h5, 1,16'h203C,16'h2));
        vecs.push_back(mk(0,1,0,0, 1,16'h6, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h7, 1,16'h1122,16'h4));
        // Decode stalled: FIFO fills to two entries, reads stop, then drain in order.
        vecs.push_back(mk(1,0,0,0, 1,16'h0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'h1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'h2, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'h3, 1,THUMB_NOP,16'h0));
        vecs.push_back(mk(0,0,0,0, 0,16'h0, 1,THUMB_NOP,16'h0));
        vecs.push_back(mk(0,0,0,0, 0,16'h0, 1,THUMB_NOP,16'h0));
        vecs.push_back(mk(0,0,0,0, 0,16'h0, 1,THUMB_NOP,16'h0));
        vecs.push_back(mk(0,1,0,0, 1,16'h4, 1,THUMB_NOP,16'h0));
        vecs.push_back(mk(0,1,0,0, 1,16'h5, 1,16'h203C,16'h2));
        vecs.push_back(mk(0,1,0,0, 1,16'h6, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h7, 1,16'h1122,16'h4));
        // Push and pop on the same edge with one entry held.
        vecs.push_back(mk(1,0,0,0, 1,16'h0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'h1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'h2, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,16'h3, 1,THUMB_NOP,16'h0));
        vecs.push_back(mk(0,1,0,0, 1,16'h4, 1,THUMB_NOP,16'h0));
        vecs.push_back(mk(0,1,0,0, 1,16'h5, 1,16'h203C,16'h2));
        vecs.push_back(mk(0,1,0,0, 1,16'h6, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h7, 1,16'h1122,16'h4));
        vecs.push_back(mk(0,1,0,0, 1,16'h8, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h9, 1,16'h3344,16'h6));
        // Redirect to an odd target during a lo read with an entry waiting.
        vecs.push_back(mk(1,1,0,0, 1,16'h0, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h1, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h2, 0,0,0));
        vecs.push_back(mk(0,1,1,16'h0013, 0,16'h0, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h12, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h13, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h14, 0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,16'h15, 1,16'h487A,16'h12));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doReset) doReset();
            else @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkOutput(i, vecs[i]);
        end

        // Fetch PC wraps from 0xFFFE to 0x0000.
        doReset();
        #2;
        check("wrap addr c0", memAddrB, 16'hFFFE);
        @(negedge clk); #2;
        check("wrap addr c1", memAddrB, 16'hFFFF);
        @(negedge clk); #2;
        check("wrap addr c2", memAddrB, 16'h0000);
        @(negedge clk); #2;
        check("wrap valid c3", {15'b0, outValidB}, 16'h1);
        check("wrap instr c3", outInstrB, THUMB_NOP);
        check("wrap pc c3", outPcB, 16'hFFFE);
        @(negedge clk); #2;
        check("wrap valid c4", {15'b0, outValidB}, 16'h0);
        @(negedge clk); #2;
        check("wrap valid c5", {15'b0, outValidB}, 16'h1);
        check("wrap instr c5", outInstrB, 16'h2005);
        check("wrap pc c5", outPcB, 16'h0000);

        // Async reset pulse during a lo read clears outputs without a clock edge.
        doReset();
        outReadyA = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("midrst pre valid", {15'b0, outValidA}, 16'h1);
        rst = 1'b0;
        #1;
        check("midrst valid", {15'b0, outValidA}, 16'h0);
        check("midrst instr", outInstrA, 16'h0);
        check("midrst pc", outPcA, 16'h0);
        check("midrst rd_en", {15'b0, memRdEnA}, 16'h0);
        check("midrst addr", memAddrA, 16'h0);
        #4;
        rst = 1'b1;
        @(negedge clk); #2;
        check("midrst c0 addr", memAddrA, 16'h0);
        check("midrst c0 valid", {15'b0, outValidA}, 16'h0);
        repeat (3) @(negedge clk);
        #2;
        check("midrst c3 valid", {15'b0, outValidA}, 16'h1);
        check("midrst c3 instr", outInstrA, THUMB_NOP);
        check("midrst c3 pc", outPcA, 16'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
